// File: rtl/trigger_delay_burst.sv
// Delayed trigger burst generator: counts synchronised target_clk ticks, then emits COUNT pulses of WIDTH/GAP ticks.
// Optional abort input when TRIG_ABORT_EN is defined.
module trigger_delay_burst #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned WIDTH_W     = 16,
  parameter int unsigned PULSES_W    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  input  logic                target_clk,
  input  logic [CNT_W-1:0]    delay,
  input  logic [WIDTH_W-1:0]  width,
  input  logic [WIDTH_W-1:0]  gap,
  input  logic [PULSES_W-1:0] count,
  input  logic                set_config,
`ifdef TRIG_ABORT_EN
  input  logic                abort,
`endif
  output logic                delayed_trigger,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACTIVE, S_GAP, S_FINISHED} state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   tick_q;

  logic [CNT_W-1:0]    cfg_delay, delay_s, delay_s_nx, elapsed, elapsed_nx;
  logic [WIDTH_W-1:0]  cfg_width, width_s, width_s_nx, hi, hi_nx;
  logic [WIDTH_W-1:0]  cfg_gap, gap_s, gap_s_nx, lo, lo_nx;
  logic [PULSES_W-1:0] cfg_count, count_s, count_s_nx, pulses, pulses_nx;
  logic                out_nx, busy_nx, done_nx;

  // Target clock synchroniser and rising-edge detect into a registered one-clk tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], target_clk};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
      tick_q      <= sync_q[SYNC_STAGES-1] & ~sync_prev_q;
    end
  end

  // Configuration registers, loadable in any state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_delay <= '0;
      cfg_width <= '0;
      cfg_gap   <= '0;
      cfg_count <= '0;
    end else if (set_config) begin
      cfg_delay <= delay;
      cfg_width <= width;
      cfg_gap   <= gap;
      cfg_count <= count;
    end
  end

  // State, snapshot, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      delay_s         <= '0;
      width_s         <= '0;
      gap_s           <= '0;
      count_s         <= '0;
      elapsed         <= '0;
      hi              <= '0;
      lo              <= '0;
      pulses          <= '0;
      delayed_trigger <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_nx;
      delay_s         <= delay_s_nx;
      width_s         <= width_s_nx;
      gap_s           <= gap_s_nx;
      count_s         <= count_s_nx;
      elapsed         <= elapsed_nx;
      hi              <= hi_nx;
      lo              <= lo_nx;
      pulses          <= pulses_nx;
      delayed_trigger <= out_nx;
      busy            <= busy_nx;
      done            <= done_nx;
    end
  end

  // Next-state and output logic; all counting is gated by tick_q
  always_comb begin
    state_nx   = state;
    delay_s_nx = delay_s;
    width_s_nx = width_s;
    gap_s_nx   = gap_s;
    count_s_nx = count_s;
    elapsed_nx = elapsed;
    hi_nx      = hi;
    lo_nx      = lo;
    pulses_nx  = pulses;
    out_nx     = delayed_trigger;

    case (state)
      S_IDLE: begin
        out_nx = 1'b0;
        if (trigger) begin
          delay_s_nx = cfg_delay;
          width_s_nx = (cfg_width == '0) ? WIDTH_W'(1) : cfg_width;
          gap_s_nx   = cfg_gap;
          count_s_nx = (cfg_count == '0) ? PULSES_W'(1) : cfg_count;
          elapsed_nx = '0;
          hi_nx      = '0;
          lo_nx      = '0;
          pulses_nx  = '0;
          state_nx   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tick_q) begin
          if (elapsed == delay_s) begin
            state_nx = S_ACTIVE;
            out_nx   = 1'b1;
            hi_nx    = WIDTH_W'(1);
          end else begin
            elapsed_nx = elapsed + CNT_W'(1);
          end
        end
      end
      S_ACTIVE: begin
        if (tick_q) begin
          if (hi != width_s) begin
            hi_nx = hi + WIDTH_W'(1);
          end else if (pulses + PULSES_W'(1) == count_s) begin
            state_nx = S_FINISHED;
            out_nx   = 1'b0;
          end else if (gap_s == '0) begin
            // Zero gap: consecutive pulses merge into one long high
            hi_nx     = WIDTH_W'(1);
            pulses_nx = pulses + PULSES_W'(1);
          end else begin
            state_nx  = S_GAP;
            out_nx    = 1'b0;
            lo_nx     = WIDTH_W'(1);
            pulses_nx = pulses + PULSES_W'(1);
          end
        end
      end
      S_GAP: begin
        if (tick_q) begin
          if (lo == gap_s) begin
            state_nx = S_ACTIVE;
            out_nx   = 1'b1;
            hi_nx    = WIDTH_W'(1);
          end else begin
            lo_nx = lo + WIDTH_W'(1);
          end
        end
      end
      S_FINISHED: begin
        out_nx = 1'b0;
        if (!trigger) state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
        out_nx   = 1'b0;
      end
    endcase

`ifdef TRIG_ABORT_EN
    if (abort && (state != S_IDLE)) begin
      state_nx = S_FINISHED;
      out_nx   = 1'b0;
    end
`endif

    busy_nx = (state_nx != S_IDLE);
    done_nx = (state_nx == S_FINISHED) && (state != S_FINISHED);
  end

endmodule

// File: tb/tb_trigger_delay_burst.sv
// Bench for trigger_delay_burst: tick-level burst model checked every clk, plus literal pins per scenario.
module tb_trigger_delay_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic        target_clk;
  logic [31:0] delay;
  logic [15:0] width;
  logic [15:0] gap;
  logic [7:0]  count;
  logic        set_config;
`ifdef TRIG_ABORT_EN
  logic        abort;
`endif
  logic        delayed_trigger;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  // model state
  longint m_delay, m_width, m_gap, m_count;
  longint s_delay, s_width, s_gap, s_count, s_fin;
  longint n_ticks;
  bit     m_run;
  logic   exp_out, exp_busy, exp_done;

  trigger_delay_burst dut (
    .clk             (clk),
    .rst             (rst),
    .trigger         (trigger),
    .target_clk      (target_clk),
    .delay           (delay),
    .width           (width),
    .gap             (gap),
    .count           (count),
    .set_config      (set_config),
`ifdef TRIG_ABORT_EN
    .abort           (abort),
`endif
    .delayed_trigger (delayed_trigger),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, expv);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Output is high on tick n iff n falls inside one of the count pulse windows
  function automatic logic in_pulse(input longint n);
    longint off;
    if (n < s_delay + 1 || n >= s_fin) return 1'b0;
    off = (n - s_delay - 1) % (s_width + s_gap);
    return (off < s_width) ? 1'b1 : 1'b0;
  endfunction

  // Per-cycle compare against the model
  always @(posedge clk) begin
    #2;
    chk("out", delayed_trigger, exp_out);
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    if (done === 1'b1) done_cnt++;
  end

  task automatic set_cfg(input longint d, input longint w, input longint g, input longint c);
    delay = 32'(d);
    width = 16'(w);
    gap = 16'(g);
    count = 8'(c);
    set_config = 1'b1;
    m_delay = d; m_width = w; m_gap = g; m_count = c;
    @(negedge clk);
    set_config = 1'b0;
  endtask

  task automatic model_accept();
    s_delay = m_delay;
    s_width = (m_width == 0) ? 1 : m_width;
    s_gap   = m_gap;
    s_count = (m_count == 0) ? 1 : m_count;
    s_fin   = s_delay + 1 + s_count * s_width + (s_count - 1) * s_gap;
    n_ticks = 0;
    m_run = 1'b1;
    exp_busy = 1'b1;
    exp_out = 1'b0;
  endtask

  task automatic accept();
    trigger = 1'b1;
    model_accept();
    @(negedge clk);
  endtask

  // One target clock period of 8 clks; DUT output moves 4 clk edges after the rise
  task automatic tick();
    target_clk = 1'b1;
    repeat (3) @(negedge clk);
    if (m_run) begin
      n_ticks++;
      if (n_ticks == s_fin) begin
        exp_out = 1'b0;
        exp_done = 1'b1;
        m_run = 1'b0;
      end else begin
        exp_out = in_pulse(n_ticks);
      end
    end
    @(negedge clk);
    exp_done = 1'b0;
    target_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic drop_trigger();
    trigger = 1'b0;
    if (!m_run) exp_busy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] t2_pat;
    rst = 1'b0;
    trigger = 1'b0;
    target_clk = 1'b0;
    delay = '0; width = '0; gap = '0; count = '0;
    set_config = 1'b0;
`ifdef TRIG_ABORT_EN
    abort = 1'b0;
`endif
    m_delay = 0; m_width = 0; m_gap = 0; m_count = 0;
    m_run = 1'b0;
    exp_out = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // delay=3 width=2 single pulse: high over ticks 4..5
    set_cfg(3, 2, 0, 1);
    done_cnt = 0;
    accept();
    repeat (3) tick();
    chk("t1_pre_rise", delayed_trigger, 1'b0);
    tick();
    chk("t1_rise_tick4", delayed_trigger, 1'b1);
    tick();
    chk("t1_high_tick5", delayed_trigger, 1'b1);
    tick();
    chk("t1_fall_tick6", delayed_trigger, 1'b0);
    repeat (3) @(negedge clk);
    chk("t1_busy_held", busy, 1'b1);
    chk_int("t1_done_count", done_cnt, 1);
    drop_trigger();
    @(negedge clk);
    chk("t1_busy_low", busy, 1'b0);

    // delay=0 width=1 gap=2 count=3: highs on ticks 1, 4, 7
    set_cfg(0, 1, 2, 3);
    accept();
    t2_pat = 8'b0100_1001;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t2_tick%0d", i + 1), delayed_trigger, t2_pat[i]);
    end
    chk("t2_busy_fin", busy, 1'b1);
    drop_trigger();

    // width=0 count=0 normalise to a single one-tick pulse at tick 6
    set_cfg(5, 0, 2, 0);
    accept();
    repeat (5) tick();
    chk("t3_tick5", delayed_trigger, 1'b0);
    tick();
    chk("t3_tick6", delayed_trigger, 1'b1);
    tick();
    chk("t3_tick7", delayed_trigger, 1'b0);
    drop_trigger();

    // Mid-burst reconfig only affects the next burst
    set_cfg(10, 1, 0, 1);
    accept();
    repeat (4) tick();
    set_cfg(1, 1, 0, 1);
    repeat (6) tick();
    chk("t4_tick10", delayed_trigger, 1'b0);
    tick();
    chk("t4_tick11", delayed_trigger, 1'b1);
    tick();
    drop_trigger();
    accept();
    tick();
    chk("t4b_tick1", delayed_trigger, 1'b0);
    tick();
    chk("t4b_tick2", delayed_trigger, 1'b1);
    tick();
    drop_trigger();

    // Async reset mid-pulse, then a held trigger restarts with zeroed config
    set_cfg(2, 3, 1, 2);
    accept();
    repeat (4) tick();
    chk("t5_active", delayed_trigger, 1'b1);
    #3;
    rst = 1'b0;
    m_run = 1'b0;
    exp_out = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    m_delay = 0; m_width = 0; m_gap = 0; m_count = 0;
    #1;
    chk("t5_async_out", delayed_trigger, 1'b0);
    chk("t5_async_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_accept();
    @(negedge clk);
    chk("t5_restart_busy", busy, 1'b1);
    tick();
    chk("t5_tick1", delayed_trigger, 1'b1);
    tick();
    chk("t5_tick2", delayed_trigger, 1'b0);
    drop_trigger();

`ifdef TRIG_ABORT_EN
    // Abort during the gap of a four-pulse burst
    set_cfg(0, 1, 2, 4);
    done_cnt = 0;
    accept();
    tick();
    chk("t6_tick1", delayed_trigger, 1'b1);
    tick();
    abort = 1'b1;
    m_run = 1'b0;
    exp_out = 1'b0;
    exp_done = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_done = 1'b0;
    repeat (4) tick();
    chk("t6_no_pulse", delayed_trigger, 1'b0);
    chk_int("t6_done_count", done_cnt, 1);
    drop_trigger();
    @(negedge clk);
    chk("t6_idle", busy, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
